// File: rtl/fetch_buffer.sv
// In-order instruction fetch buffer between the PC stage and decode.
// Issues memory reads, collects responses with their PC, and squashes stale responses after a redirect.
module fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            redirect,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_misaligned
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, filled_q, mis_q;
    logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d, dropCnt_q, dropCnt_d;

    logic aligned, space, admit, alloc, pop, rspLive, dropping, fill, fillHit;
    logic [PW-1:0] fillIdx, scanIdx;
    logic [CW-1:0] unfilledCnt, inFlight;
    logic [DEPTH-1:0] pending;

    assign pending = valid_q & ~filled_q;

    // Responses return in request order, so they belong to the oldest entry still waiting for data.
    always_comb begin
        fillHit     = 1'b0;
        fillIdx     = '0;
        scanIdx     = '0;
        unfilledCnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = rdPtr_q + PW'(i);
            if (pending[scanIdx] && !fillHit) begin
                fillHit = 1'b1;
                fillIdx = scanIdx;
            end
            unfilledCnt = unfilledCnt + CW'(pending[i]);
        end
    end

    assign inFlight       = dropCnt_q + unfilledCnt;
    assign aligned        = (pc_in[1:0] == 2'b00);
    // Squashed requests still occupy memory slots, so they count against capacity.
    assign space          = ({1'b0, count_q} + {1'b0, dropCnt_q}) < DepthW;
    assign admit          = pc_valid & space & ~redirect & ~rst;
    assign imem_req_valid = admit & aligned;
    assign imem_req_addr  = pc_in;
    assign pc_ready       = aligned ? (imem_req_valid & imem_req_ready) : admit;
    assign alloc          = pc_ready;

    assign inst_valid      = valid_q[rdPtr_q] & filled_q[rdPtr_q];
    assign inst_out        = data_q[rdPtr_q];
    assign inst_pc         = pc_q[rdPtr_q];
    assign inst_misaligned = inst_valid & mis_q[rdPtr_q];

    assign pop      = inst_valid & inst_ready & ~redirect;
    assign rspLive  = imem_rsp_valid & ~redirect;
    assign dropping = rspLive & (dropCnt_q != '0);
    assign fill     = rspLive & (dropCnt_q == '0) & fillHit;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        dropCnt_d = dropCnt_q;
        if (redirect) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            dropCnt_d = inFlight - CW'(imem_rsp_valid && (inFlight != '0));
        end else begin
            wrPtr_d   = wrPtr_q + PW'(alloc);
            rdPtr_d   = rdPtr_q + PW'(pop);
            count_d   = count_q + CW'(alloc) - CW'(pop);
            dropCnt_d = dropCnt_q - CW'(dropping);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            dropCnt_q <= '0;
            valid_q   <= '0;
            filled_q  <= '0;
            mis_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            dropCnt_q <= dropCnt_d;
            if (redirect) begin
                valid_q  <= '0;
                filled_q <= '0;
                mis_q    <= '0;
            end else begin
                if (fill) begin
                    data_q[fillIdx]   <= imem_rsp_data;
                    filled_q[fillIdx] <= 1'b1;
                end
                if (pop) begin
                    valid_q[rdPtr_q] <= 1'b0;
                end
                // Misaligned fetches never reach memory and are complete the moment they are allocated.
                if (alloc) begin
                    pc_q[wrPtr_q]     <= pc_in;
                    data_q[wrPtr_q]   <= '0;
                    valid_q[wrPtr_q]  <= 1'b1;
                    filled_q[wrPtr_q] <= ~aligned;
                    mis_q[wrPtr_q]    <= ~aligned;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized and directed bench for fetch_buffer against a queue-based model of the buffer
// and an in-order memory with configurable latency.
module tb_fetch_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            redirect;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc;
    logic            inst_misaligned;

    fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .redirect(redirect),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .inst_misaligned(inst_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        bit          filled;
        bit          mis;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    entry_t  model[$];
    memreq_t memQ[$];
    int      dropCnt = 0;
    int      cyc = 0;
    int      lastDue = 0;
    int      memDelay = 1;
    bit      rspGate = 1'b1;
    bit      lastPcReady;
    int      checkCount = 0;
    int      passCount = 0;

    function automatic logic [31:0] memData(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00a0_0113;
            32'h8:   return 32'h0020_81b3;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        else
            passCount++;
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then advance model and memory.
    task automatic applyStimulus(input bit pv, input logic [31:0] pcv, input bit redir,
                                 input bit memRdy, input bit instRdy);
        bit expSpace, expAlign, expReqV, expPcReady, expInstV, rsp, done;
        logic [31:0] rdata;
        int unf;
        entry_t e;
        pc_valid       = pv;
        pc_in          = pcv;
        redirect       = redir;
        imem_req_ready = memRdy;
        inst_ready     = instRdy;
        rsp            = (memQ.size() > 0) && (memQ[0].due <= cyc) && rspGate;
        rdata          = rsp ? memData(memQ[0].addr) : 32'($urandom);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        @(negedge clk);
        expSpace   = (model.size() + dropCnt) < DEPTH;
        expAlign   = (pcv[1:0] == 2'b00);
        expReqV    = pv && expAlign && expSpace && !redir;
        expPcReady = pv && expSpace && !redir && (expAlign ? memRdy : 1'b1);
        expInstV   = (model.size() > 0) && model[0].filled;
        lastPcReady = pc_ready;
        checkOutput("pc_ready", 32'(pc_ready), 32'(expPcReady));
        checkOutput("imem_req_valid", 32'(imem_req_valid), 32'(expReqV));
        if (expReqV) checkOutput("imem_req_addr", imem_req_addr, pcv);
        checkOutput("inst_valid", 32'(inst_valid), 32'(expInstV));
        if (expInstV) begin
            checkOutput("inst_out", inst_out, model[0].data);
            checkOutput("inst_pc", inst_pc, model[0].pc);
            checkOutput("inst_misaligned", 32'(inst_misaligned), 32'(model[0].mis));
        end
        if (imem_req_valid && imem_req_ready) begin
            lastDue = (cyc + memDelay > lastDue) ? cyc + memDelay : lastDue;
            memQ.push_back('{addr: imem_req_addr, due: lastDue});
        end
        if (rsp) void'(memQ.pop_front());
        if (redir) begin
            unf = dropCnt;
            foreach (model[i]) if (!model[i].filled) unf++;
            if (rsp && unf > 0) unf--;
            dropCnt = unf;
            model.delete();
        end else begin
            if (rsp) begin
                if (dropCnt > 0) dropCnt--;
                else begin
                    done = 1'b0;
                    foreach (model[i]) begin
                        if (!model[i].filled && !done) begin
                            model[i].data   = rdata;
                            model[i].filled = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (expInstV && instRdy) void'(model.pop_front());
            if (expPcReady) begin
                e.pc = pcv; e.data = 32'h0; e.filled = !expAlign; e.mis = !expAlign;
                model.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++)
            if (memQ.size() != 0 || model.size() != 0) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int pulses;
        logic [31:0] addr;
        rst = 1'b1;
        pc_valid = 1'b1; pc_in = 32'h0; redirect = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_pc_ready", 32'(pc_ready), 32'h0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst_out", inst_out, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        checkOutput("rst_inst_mis", 32'(inst_misaligned), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] basic in-order fetch");
        memDelay = 1;
        applyStimulus(1, 32'h0, 0, 1, 1);
        applyStimulus(1, 32'h4, 0, 1, 1);
        applyStimulus(1, 32'h8, 0, 1, 1);
        drain();

        $display("[TB] fill to capacity");
        pulses = 0; addr = 32'h1000;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, addr, 0, 1, 0);
            if (lastPcReady) begin pulses++; addr += 4; end
        end
        checkOutput("full_pulses", 32'(pulses), 32'(DEPTH));
        pulses = 0;
        applyStimulus(1, addr, 0, 1, 1);
        if (lastPcReady) begin pulses++; addr += 4; end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, addr, 0, 1, 0);
            if (lastPcReady) begin pulses++; addr += 4; end
        end
        checkOutput("refill_pulses", 32'(pulses), 32'h1);
        drain();

        $display("[TB] redirect with three in flight");
        memDelay = 4;
        applyStimulus(1, 32'h10, 0, 1, 1);
        applyStimulus(1, 32'h14, 0, 1, 1);
        applyStimulus(1, 32'h18, 0, 1, 1);
        applyStimulus(0, 32'h0, 1, 1, 1);
        memDelay = 1;
        applyStimulus(1, 32'h100, 0, 1, 1);
        drain();

        $display("[TB] redirect coinciding with a response");
        memDelay = 3;
        applyStimulus(1, 32'h20, 0, 1, 1);
        applyStimulus(1, 32'h24, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 1, 1);
        applyStimulus(0, 32'h0, 1, 1, 1);
        applyStimulus(1, 32'h30, 0, 1, 1);
        drain();

        $display("[TB] misaligned fetch");
        memDelay = 1;
        applyStimulus(1, 32'h0000_0102, 0, 1, 1);
        applyStimulus(0, 32'h0, 0, 1, 1);
        drain();

        $display("[TB] async reset with requests in flight");
        applyStimulus(1, 32'h40, 0, 1, 0);
        memDelay = 5;
        applyStimulus(1, 32'h44, 0, 1, 0);
        applyStimulus(1, 32'h48, 0, 1, 0);
        applyStimulus(0, 32'h0, 0, 1, 0);
        checkOutput("pre_rst_inst_valid", 32'(inst_valid), 32'h1);
        pc_valid = 1'b1; pc_in = 32'h60;
        rst = 1'b1;
        #1;
        checkOutput("async_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("async_inst_out", inst_out, 32'h0);
        checkOutput("async_inst_pc", inst_pc, 32'h0);
        checkOutput("async_pc_ready", 32'(pc_ready), 32'h0);
        checkOutput("async_req_valid", 32'(imem_req_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        model.delete();
        dropCnt = 0;
        drain();
        memDelay = 1;
        applyStimulus(1, 32'h50, 0, 1, 1);
        drain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            memDelay = $urandom_range(1, 4);
            rspGate  = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 9) < 7, addr, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        rspGate = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
